// File: rtl/rf_scoreboard_ctrl.sv
// Register-file access controller: a busy scoreboard for long-latency destinations,
// RAW/WAW/capacity issue stalls, and arbitration of the single RF write port between
// fixed-latency writeback and long-unit results.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are high at the
// rising clock edge. Ready never depends on the same channel's valid. wb has no ready
// and is always taken. The long unit must hold lu_valid/lu_rd/lu_data until it sees
// lu_ready high. Decode must hold its issue fields until it sees issue_ready high.
module rf_scoreboard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_LONG = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [ADDR_W-1:0]               issue_rs1,
    input  logic [ADDR_W-1:0]               issue_rs2,
    input  logic [ADDR_W-1:0]               issue_rd,
    input  logic                            issue_wr,
    input  logic                            issue_long,
    output logic                            issue_ready,
    input  logic                            wb_valid,
    input  logic [ADDR_W-1:0]               wb_rd,
    input  logic [DATA_W-1:0]               wb_data,
    input  logic                            lu_valid,
    input  logic [ADDR_W-1:0]               lu_rd,
    input  logic [DATA_W-1:0]               lu_data,
    output logic                            lu_ready,
    output logic                            rf_regwrite,
    output logic [ADDR_W-1:0]               rf_writereg,
    output logic [DATA_W-1:0]               rf_writedata,
    output logic [NUM_REGS-1:0]             busy_mask,
    output logic [$clog2(MAX_LONG+1)-1:0]   outstanding,
    output logic                            sb_err
);

    localparam int CW = $clog2(MAX_LONG + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    logic                raw;
    logic                waw;
    logic                full;
    logic                issue_set;
    logic                lu_fire;
    logic                lu_clr;
    logic                lu_orphan;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CW-1:0]       cnt_nxt;

    // Hazard detection from registered scoreboard only; bit 0 is never set so x0 never stalls.
    always_comb begin
        raw         = busy_mask[issue_rs1] | busy_mask[issue_rs2];
        waw         = issue_wr & busy_mask[issue_rd];
        full        = issue_wr & issue_long & (outstanding == MAX_CNT);
        issue_ready = ~(raw | waw | full);
    end

    // Write-port arbitration: fixed-latency writeback always wins, long unit takes idle slots.
    always_comb begin
        lu_ready     = ~wb_valid;
        rf_regwrite  = 1'b0;
        rf_writereg  = '0;
        rf_writedata = '0;
        if (wb_valid) begin
            rf_regwrite  = (wb_rd != '0);
            rf_writereg  = wb_rd;
            rf_writedata = wb_data;
        end else if (lu_valid) begin
            rf_regwrite  = (lu_rd != '0);
            rf_writereg  = lu_rd;
            rf_writedata = lu_data;
        end
    end

    // Scoreboard next state: claim on long issue, release on long-unit completion.
    always_comb begin
        issue_set = issue_valid & issue_ready & issue_wr & issue_long & (issue_rd != '0);
        lu_fire   = lu_valid & lu_ready;
        lu_clr    = lu_fire & busy_mask[lu_rd];
        lu_orphan = lu_fire & (lu_rd != '0) & ~busy_mask[lu_rd];

        busy_nxt = busy_mask;
        if (issue_set) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        if (lu_clr) begin
            busy_nxt[lu_rd] = 1'b0;
        end
        busy_nxt[0] = 1'b0;

        // A claim and a release in the same cycle hit different registers (WAW stalls
        // the same-register case), so the count simply stays put.
        cnt_nxt = outstanding;
        case ({issue_set, lu_clr})
            2'b10:   cnt_nxt = outstanding + ONE_CNT;
            2'b01:   cnt_nxt = outstanding - ONE_CNT;
            default: cnt_nxt = outstanding;
        endcase
    end

    // Registered scoreboard state; reset drops all pending ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask   <= '0;
            outstanding <= '0;
            sb_err      <= 1'b0;
        end else begin
            busy_mask   <= busy_nxt;
            outstanding <= cnt_nxt;
            if (lu_orphan) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard_ctrl.sv
// Directed bench for rf_scoreboard_ctrl: hand-computed expectations, RF writes checked
// against an expected queue by a negedge monitor.
module tb_rf_scoreboard_ctrl;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_LONG = 4;
    localparam int CW       = $clog2(MAX_LONG + 1);

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rs1;
    logic [ADDR_W-1:0]   issue_rs2;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_wr;
    logic                issue_long;
    logic                issue_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                lu_valid;
    logic [ADDR_W-1:0]   lu_rd;
    logic [DATA_W-1:0]   lu_data;
    logic                lu_ready;
    logic                rf_regwrite;
    logic [ADDR_W-1:0]   rf_writereg;
    logic [DATA_W-1:0]   rf_writedata;
    logic [NUM_REGS-1:0] busy_mask;
    logic [CW-1:0]       outstanding;
    logic                sb_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    rf_scoreboard_ctrl #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LONG(MAX_LONG)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_long(issue_long),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata),
        .busy_mask(busy_mask), .outstanding(outstanding), .sb_err(sb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        issue_wr = 1'b0; issue_long = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic [ADDR_W-1:0] rd, input logic wr, input logic lng);
        issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_wr = wr; issue_long = lng;
    endtask

    task automatic lu(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        lu_valid = 1'b1; lu_rd = rd; lu_data = d;
    endtask

    task automatic wb(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic exp_write(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    // scoreboard: every RF write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst === 1'b0 && rf_regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(rf_regwrite), 64'(0));
            end else begin
                check("wr_data", 64'({rf_writereg, rf_writedata}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;

        // 1: reset
        cyc();
        cyc();
        @(negedge clk);
        check("rst_busy", 64'(busy_mask), 64'(0));
        check("rst_outst", 64'(outstanding), 64'(0));
        check("rst_err", 64'(sb_err), 64'(0));
        check("rst_ready", 64'(issue_ready), 64'(1));
        check("rst_regwr", 64'(rf_regwrite), 64'(0));
        rst = 1'b0;
        cyc();

        // 2: RAW on a long destination, released by completion
        issue(0, 0, 5, 1, 1);
        @(negedge clk);
        check("t2_issue_rdy", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        issue(5, 0, 0, 0, 0);
        lu(5, 32'hDEADBEEF);
        exp_write(5, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_raw_stall", 64'(issue_ready), 64'(0));
        check("t2_lu_ready", 64'(lu_ready), 64'(1));
        check("t2_busy", 64'(busy_mask), 64'h20);
        check("t2_outst", 64'(outstanding), 64'(1));
        cyc();
        idle();
        issue(5, 0, 0, 0, 0);
        @(negedge clk);
        check("t2_rdy_after", 64'(issue_ready), 64'(1));
        check("t2_busy_clr", 64'(busy_mask), 64'(0));
        check("t2_outst_clr", 64'(outstanding), 64'(0));
        cyc();

        // 3: wb beats lu; lu lands the following cycle
        idle();
        issue(0, 0, 7, 1, 1);
        cyc();
        idle();
        issue(0, 7, 0, 0, 0);
        wb(3, 32'h33);
        lu(7, 32'h77);
        exp_write(3, 32'h33);
        @(negedge clk);
        check("t3_lu_blocked", 64'(lu_ready), 64'(0));
        check("t3_rs2_stall", 64'(issue_ready), 64'(0));
        cyc();
        idle();
        issue(0, 0, 7, 1, 0);
        lu(7, 32'h77);
        exp_write(7, 32'h77);
        @(negedge clk);
        check("t3_lu_ready", 64'(lu_ready), 64'(1));
        check("t3_waw_stall", 64'(issue_ready), 64'(0));
        check("t3_busy7", 64'(busy_mask), 64'h80);
        cyc();
        idle();
        @(negedge clk);
        check("t3_busy_clr", 64'(busy_mask), 64'(0));
        check("t3_err", 64'(sb_err), 64'(0));
        check("t3_idle_reg", 64'(rf_writereg), 64'(0));
        check("t3_idle_data", 64'(rf_writedata), 64'(0));
        cyc();

        // 4: fill to MAX_LONG, full stall, concurrent claim + release
        for (int r = 1; r <= 4; r++) begin
            issue(0, 0, ADDR_W'(r), 1, 1);
            @(negedge clk);
            check("t4_fill_rdy", 64'(issue_ready), 64'(1));
            cyc();
        end
        idle();
        issue(0, 0, 9, 1, 1);
        @(negedge clk);
        check("t4_outst_full", 64'(outstanding), 64'(4));
        check("t4_busy_full", 64'(busy_mask), 64'h1E);
        check("t4_full_stall", 64'(issue_ready), 64'(0));
        cyc();
        issue(0, 0, 9, 1, 0);
        @(negedge clk);
        check("t4_short_ok", 64'(issue_ready), 64'(1));
        cyc();
        issue(0, 0, 9, 1, 1);
        lu(2, 32'h22);
        exp_write(2, 32'h22);
        @(negedge clk);
        check("t4_still_full", 64'(issue_ready), 64'(0));
        cyc();
        lu(1, 32'h11);
        exp_write(1, 32'h11);
        @(negedge clk);
        check("t4_outst3", 64'(outstanding), 64'(3));
        check("t4_rdy_freed", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        @(negedge clk);
        check("t4_set_clr_outst", 64'(outstanding), 64'(3));
        check("t4_set_clr_busy", 64'(busy_mask), 64'h218);
        cyc();
        lu(3, 32'h30); exp_write(3, 32'h30); cyc();
        lu(4, 32'h40); exp_write(4, 32'h40); cyc();
        lu(9, 32'h90); exp_write(9, 32'h90); cyc();
        idle();
        @(negedge clk);
        check("t4_drain_busy", 64'(busy_mask), 64'(0));
        check("t4_drain_outst", 64'(outstanding), 64'(0));
        check("t4_drain_err", 64'(sb_err), 64'(0));
        cyc();

        // 5: x0 destination is never tracked and never written
        issue(0, 0, 0, 1, 1);
        @(negedge clk);
        check("t5_x0_rdy", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        lu(0, 32'h55);
        @(negedge clk);
        check("t5_x0_busy", 64'(busy_mask), 64'(0));
        check("t5_x0_outst", 64'(outstanding), 64'(0));
        check("t5_x0_lu_regwr", 64'(rf_regwrite), 64'(0));
        check("t5_x0_lu_ready", 64'(lu_ready), 64'(1));
        cyc();
        idle();
        wb(0, 32'h66);
        @(negedge clk);
        check("t5_x0_err", 64'(sb_err), 64'(0));
        check("t5_x0_wb_regwr", 64'(rf_regwrite), 64'(0));
        cyc();

        // 6: orphan completion is sticky; reset clears everything
        idle();
        lu(12, 32'hC0C0);
        exp_write(12, 32'hC0C0);
        cyc();
        idle();
        @(negedge clk);
        check("t6_err_set", 64'(sb_err), 64'(1));
        cyc();
        issue(0, 0, 6, 1, 1);
        @(negedge clk);
        check("t6_err_sticky", 64'(sb_err), 64'(1));
        cyc();
        idle();
        @(negedge clk);
        check("t6_busy6", 64'(busy_mask), 64'h40);
        check("t6_outst1", 64'(outstanding), 64'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", 64'(busy_mask), 64'(0));
        check("t6_rst_outst", 64'(outstanding), 64'(0));
        check("t6_rst_err", 64'(sb_err), 64'(0));
        check("t6_rst_ready", 64'(issue_ready), 64'(1));
        cyc();

        // final report
        check("wr_pending", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
